// File: rtl/dec_sel_sequencer.sv
// Select/enable sequencer feeding a 2-to-4 decoder: conditions the raw pad inputs,
// then advances the select by debounced manual steps, an auto-scan prescaler or a direct load.
module dec_sel_sequencer #(
    parameter int DEB_CYCLES = 4,
    parameter int SCAN_DIV   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       step_in,
    input  logic       load_in,
    input  logic       auto_mode,
    input  logic [1:0] sel_load,
    output logic [1:0] sel,
    output logic       sel_en,
    output logic       sel_upd,
    output logic [1:0] dbg_state_o
);

    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_AUTO   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic step_s1_q, step_s_q, load_s1_q, load_s_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic deb_lvl_q, deb_lvl_d;
    logic deb_lvl_prev_q, load_prev_q;
    logic step_p_q, load_p_q;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic tick;
    logic [1:0] sel_q, sel_d;
    logic sel_upd_q, sel_upd_d;

    // A level change is accepted only after DEB_CYCLES consecutive differing samples.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        deb_lvl_d = deb_lvl_q;
        if (step_s_q == deb_lvl_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_MAX) begin
            deb_lvl_d = ~deb_lvl_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (ena) state_d = auto_mode ? ST_AUTO : ST_MANUAL;
            ST_MANUAL: if (!ena) state_d = ST_IDLE; else if (auto_mode) state_d = ST_AUTO;
            ST_AUTO:   if (!ena) state_d = ST_IDLE; else if (!auto_mode) state_d = ST_MANUAL;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign tick = (state_q == ST_AUTO) && (scan_cnt_q == SCAN_MAX);

    // Prescaler only runs while staying in AUTO, so every AUTO entry starts from zero.
    always_comb begin
        scan_cnt_d = '0;
        if (state_q == ST_AUTO && state_d == ST_AUTO && !tick) begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
    end

    always_comb begin
        sel_d     = sel_q;
        sel_upd_d = 1'b0;
        if (state_q != ST_IDLE) begin
            if (load_p_q) begin
                sel_d     = sel_load;
                sel_upd_d = 1'b1;
            end else if (step_p_q && state_q == ST_MANUAL) begin
                sel_d     = sel_q + 2'd1;
                sel_upd_d = 1'b1;
            end else if (tick) begin
                sel_d     = sel_q + 2'd1;
                sel_upd_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            step_s1_q      <= 1'b0;
            step_s_q       <= 1'b0;
            load_s1_q      <= 1'b0;
            load_s_q       <= 1'b0;
            deb_cnt_q      <= '0;
            deb_lvl_q      <= 1'b0;
            deb_lvl_prev_q <= 1'b0;
            load_prev_q    <= 1'b0;
            step_p_q       <= 1'b0;
            load_p_q       <= 1'b0;
            scan_cnt_q     <= '0;
            sel_q          <= 2'd0;
            sel_upd_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_s1_q      <= step_in;
            step_s_q       <= step_s1_q;
            load_s1_q      <= load_in;
            load_s_q       <= load_s1_q;
            deb_cnt_q      <= deb_cnt_d;
            deb_lvl_q      <= deb_lvl_d;
            deb_lvl_prev_q <= deb_lvl_q;
            load_prev_q    <= load_s_q;
            step_p_q       <= deb_lvl_q & ~deb_lvl_prev_q;
            load_p_q       <= load_s_q & ~load_prev_q;
            scan_cnt_q     <= scan_cnt_d;
            sel_q          <= sel_d;
            sel_upd_q      <= sel_upd_d;
        end
    end

    assign sel         = sel_q;
    assign sel_upd     = sel_upd_q;
    assign sel_en      = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dec_sel_sequencer.sv
// Directed bench for dec_sel_sequencer with DEB_CYCLES=4, SCAN_DIV=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dec_sel_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       step_in;
    logic       load_in;
    logic       auto_mode;
    logic [1:0] sel_load;
    logic [1:0] sel;
    logic       sel_en;
    logic       sel_upd;
    logic [1:0] dbg_state;

    int errors = 0;
    int checks = 0;

    dec_sel_sequencer #(.DEB_CYCLES(4), .SCAN_DIV(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .step_in    (step_in),
        .load_in    (load_in),
        .auto_mode  (auto_mode),
        .sel_load   (sel_load),
        .sel        (sel),
        .sel_en     (sel_en),
        .sel_upd    (sel_upd),
        .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; step_in = 1'b0; load_in = 1'b0;
        auto_mode = 1'b0; sel_load = 2'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({sel, sel_en, sel_upd} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: sel=%0d sel_en=%b sel_upd=%b, want 0 0 0", sel, sel_en, sel_upd);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        rst_n = 1'b1; ena = 1'b1;
        @(negedge clk);
        checks++;
        if ({sel, sel_en, sel_upd} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_enter_manual: sel=%0d sel_en=%b sel_upd=%b, want 0 1 0", sel, sel_en, sel_upd);
        end
        checks++;
        if (dbg_state !== 2'd1) begin
            errors++;
            $display("FAIL reset_state_manual: got %0d want 1", dbg_state);
        end
    endtask

    // step_in rises now; sel must change exactly 8 cycles later with one pulse.
    task automatic step_press(input logic [1:0] old_v, input logic [1:0] new_v);
        int n_upd;
        n_upd = 0;
        step_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (sel_upd) n_upd++;
            if (i == 7) begin
                checks++;
                if (sel !== old_v || sel_upd !== 1'b0) begin
                    errors++;
                    $display("FAIL step_early: sel=%0d upd=%b, want %0d 0", sel, sel_upd, old_v);
                end
            end
            if (i == 8) begin
                checks++;
                if (sel !== new_v || sel_upd !== 1'b1) begin
                    errors++;
                    $display("FAIL step_latency: sel=%0d upd=%b, want %0d 1", sel, sel_upd, new_v);
                end
            end
        end
        step_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sel_upd) n_upd++;
        end
        checks++;
        if (n_upd !== 1 || sel !== new_v) begin
            errors++;
            $display("FAIL step_single_pulse: pulses=%0d sel=%0d, want 1 %0d", n_upd, sel, new_v);
        end
    endtask

    task automatic test_manual_step();
        step_press(2'd0, 2'd1);
        step_press(2'd1, 2'd2);
        step_press(2'd2, 2'd3);
        step_press(2'd3, 2'd0);
        step_press(2'd0, 2'd1);
    endtask

    task automatic test_glitch();
        logic [26:0] pat;
        int n_upd;
        int n_bad;
        pat = {3'b111, 10'b0, 4'b1010, 10'b0};
        n_upd = 0;
        n_bad = 0;
        for (int i = 26; i >= 0; i--) begin
            step_in = pat[i];
            @(negedge clk);
            if (sel_upd) n_upd++;
            if (sel !== 2'd1) n_bad++;
        end
        checks++;
        if (n_upd !== 0) begin
            errors++;
            $display("FAIL glitch_upd: pulses=%0d want 0", n_upd);
        end
        checks++;
        if (n_bad !== 0) begin
            errors++;
            $display("FAIL glitch_sel: changed cycles=%0d want 0", n_bad);
        end
    endtask

    task automatic test_async_reset();
        int n_upd;
        checks++;
        if (sel !== 2'd1) begin
            errors++;
            $display("FAIL pre_reset_sel: got %0d want 1", sel);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sel, sel_en, sel_upd} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: sel=%0d sel_en=%b upd=%b, want 0 0 0", sel, sel_en, sel_upd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_upd = 0;
        repeat (3) begin
            @(negedge clk);
            if (sel_upd) n_upd++;
        end
        checks++;
        if (n_upd !== 0 || sel !== 2'd0 || sel_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: pulses=%0d sel=%0d sel_en=%b, want 0 0 1", n_upd, sel, sel_en);
        end
    endtask

    task automatic test_auto();
        logic [1:0] exp_sel;
        logic       exp_upd;
        int n_bad;
        auto_mode = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            exp_sel = (c < 9) ? 2'd0 : (c < 17) ? 2'd1 : (c < 25) ? 2'd2 : (c < 33) ? 2'd3 : 2'd0;
            exp_upd = (c == 9 || c == 17 || c == 25 || c == 33);
            checks++;
            if (sel !== exp_sel || sel_upd !== exp_upd || sel_en !== 1'b1) begin
                errors++;
                $display("FAIL auto_scan c=%0d: sel=%0d upd=%b en=%b, want %0d %b 1",
                         c, sel, sel_upd, sel_en, exp_sel, exp_upd);
            end
            step_in = (c < 14);
        end
        auto_mode = 1'b0;
        n_bad = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (sel !== 2'd0 || sel_upd !== 1'b0) n_bad++;
        end
        checks++;
        if (n_bad !== 0 || dbg_state !== 2'd1) begin
            errors++;
            $display("FAIL auto_stop: bad cycles=%0d state=%0d, want 0 1", n_bad, dbg_state);
        end
    endtask

    task automatic test_load_tick();
        logic [1:0] exp_sel;
        logic       exp_upd;
        auto_mode = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            exp_sel = (c < 9) ? 2'd0 : (c < 17) ? 2'd1 : (c < 33) ? 2'd2 : 2'd3;
            exp_upd = (c == 9 || c == 17 || c == 25 || c == 33);
            checks++;
            if (sel !== exp_sel || sel_upd !== exp_upd) begin
                errors++;
                $display("FAIL load_tick c=%0d: sel=%0d upd=%b, want %0d %b",
                         c, sel, sel_upd, exp_sel, exp_upd);
            end
            if (c == 21) begin
                sel_load = 2'd2;
                load_in  = 1'b1;
            end
            if (c == 30) load_in = 1'b0;
        end
    endtask

    task automatic test_idle();
        int n_bad;
        ena = 1'b0;
        auto_mode = 1'b0;
        @(negedge clk);
        checks++;
        if (sel_en !== 1'b0 || sel !== 2'd3 || sel_upd !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL idle_enter: en=%b sel=%0d upd=%b state=%0d, want 0 3 0 0",
                     sel_en, sel, sel_upd, dbg_state);
        end
        n_bad = 0;
        sel_load = 2'd1;
        for (int c = 0; c < 52; c++) begin
            step_in = (c < 20);
            load_in = (c >= 32 && c < 42);
            @(negedge clk);
            if (sel !== 2'd3 || sel_upd !== 1'b0 || sel_en !== 1'b0) n_bad++;
        end
        checks++;
        if (n_bad !== 0) begin
            errors++;
            $display("FAIL idle_hold: bad cycles=%0d want 0", n_bad);
        end
        ena = 1'b1;
        @(negedge clk);
        checks++;
        if (sel_en !== 1'b1 || sel !== 2'd3 || dbg_state !== 2'd1) begin
            errors++;
            $display("FAIL idle_resume: en=%b sel=%0d state=%0d, want 1 3 1", sel_en, sel, dbg_state);
        end
        step_press(2'd3, 2'd0);
    endtask

    initial begin
        test_reset();
        test_manual_step();
        test_glitch();
        test_async_reset();
        test_auto();
        test_load_tick();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
